// File: rtl/symbol_sync_pkg.sv
// Shared definitions for the symbol-rate / sample-rate datapath blocks:
// sample width arithmetic and the legal parameter ranges.
package symbol_sync_pkg;

  localparam int unsigned SPS_MIN        = 2;
  localparam int unsigned SPS_MAX        = 16;
  localparam int unsigned FIFO_DEPTH_MIN = 2;

  // Total sample width from its sign, integer and fractional fields.
  function automatic int unsigned data_width(input int unsigned sym_w,
                                             input int unsigned int_w,
                                             input int unsigned dec_w);
    return sym_w + int_w + dec_w;
  endfunction

  function automatic bit sps_legal(input int unsigned sps);
    return (sps >= SPS_MIN) && (sps <= SPS_MAX);
  endfunction

  function automatic bit fifo_depth_legal(input int unsigned depth);
    return (depth >= FIFO_DEPTH_MIN) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Small power-of-two symbol buffer. Pointers wrap naturally modulo DEPTH;
// a write is only visible at the read port from the following clock.
module sym_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage contents.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/symbol_upsample.sv
// Symbol-to-sample upsampler: buffers Q/I symbols and emits SPS samples per
// symbol on sample_en ticks, either repeating the symbol or zero-stuffing.
module symbol_upsample
  import symbol_sync_pkg::*;
#(
  parameter  int unsigned SYM_WIDTH  = 1,
  parameter  int unsigned INT_WIDTH  = 1,
  parameter  int unsigned DEC_WIDTH  = 14,
  parameter  int unsigned SPS        = 4,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned DATA_WIDTH = data_width(SYM_WIDTH, INT_WIDTH, DEC_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sample_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_q,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic                  hold_mode,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic                  sym_start,
  output logic                  underflow,
  input  logic                  underflow_clr
);

  localparam int unsigned   PW         = $clog2(SPS);
  localparam logic [PW-1:0] LAST_PHASE = PW'(SPS - 1);

  logic [PW-1:0]           phase_q, phase_d;
  logic [2*DATA_WIDTH-1:0] cur_sym_q, cur_sym_d;
  logic                    started_q, started_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_q_q, out_q_d;
  logic [DATA_WIDTH-1:0]   out_i_q, out_i_d;
  logic                    sym_start_q, sym_start_d;
  logic                    underflow_q, underflow_d;
  logic                    set_uf;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*DATA_WIDTH-1:0] fifo_dout;

  // Ready is held low while reset is asserted.
  assign in_ready  = rstn & ~fifo_full;
  assign fifo_push = in_valid & in_ready;

  sym_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .din   ({in_q, in_i}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Phase sequencing, symbol pop and next sample value on each tick.
  always_comb begin
    phase_d     = phase_q;
    cur_sym_d   = cur_sym_q;
    started_d   = started_q;
    out_valid_d = 1'b0;
    sym_start_d = 1'b0;
    out_q_d     = out_q_q;
    out_i_d     = out_i_q;
    fifo_pop    = 1'b0;
    set_uf      = 1'b0;
    if (sample_en) begin
      out_valid_d = 1'b1;
      if (phase_q == '0) begin
        if (!fifo_empty) begin
          fifo_pop           = 1'b1;
          cur_sym_d          = fifo_dout;
          {out_q_d, out_i_d} = fifo_dout;
          sym_start_d        = 1'b1;
          started_d          = 1'b1;
          phase_d            = PW'(1);
        end else begin
          // Idle: phase parks at 0 until a symbol is available.
          {out_q_d, out_i_d} = '0;
          set_uf             = started_q;
        end
      end else begin
        {out_q_d, out_i_d} = hold_mode ? cur_sym_q : '0;
        phase_d            = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
      end
    end
    underflow_d = set_uf ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q     <= '0;
      cur_sym_q   <= '0;
      started_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_i_q     <= '0;
      sym_start_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cur_sym_q   <= cur_sym_d;
      started_q   <= started_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_i_q     <= out_i_d;
      sym_start_q <= sym_start_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_i     = out_i_q;
  assign sym_start = sym_start_q;
  assign underflow = underflow_q;

endmodule
